// File: rtl/alu_pkg.sv
// Shared opcode definitions and decode helpers for the ALU block and its bench.
// Both the RTL and the testbench import this package so opcode values exist in one place.
package alu_pkg;

    typedef enum logic [3:0] {
        AND      = 4'b0000,
        OR       = 4'b0001,
        ADD      = 4'b0010,
        SUB      = 4'b0110,
        LESSTHAN = 4'b0111,
        NOR      = 4'b1100
    } alu_op_e;

    // LESSTHAN reuses the subtract path; its result comes from the difference sign.
    function automatic logic uses_subtract(input logic [3:0] op);
        return (op == SUB) || (op == LESSTHAN);
    endfunction

    function automatic logic is_defined_op(input logic [3:0] op);
        case (op)
            AND, OR, ADD, SUB, LESSTHAN, NOR: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational W-bit adder/subtractor with signed-overflow detection.
// Subtraction is A + ~B + 1 through the same adder.
module alu_addsub #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] b_eff;

    // Overflow when the effective operands share a sign and the result does not.
    always_comb begin
        b_eff = sub ? ~B : B;
        sum   = A + b_eff + {{(W-1){1'b0}}, sub};
        ovf   = (A[W-1] == b_eff[W-1]) && (sum[W-1] != A[W-1]);
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: opcode decode, logic ops, result mux and output registers.
// One-cycle latency, a new operation accepted every cycle, synchronous active-low reset.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   ALUctl,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] ALUout,
    output logic         Overflow,
    output logic         Zero
);

    logic         use_sub;
    logic [W-1:0] sum;
    logic         ovf_as;
    logic [W-1:0] res_d;
    logic         ovf_d;

    always_comb use_sub = uses_subtract(ALUctl);

    alu_addsub #(.W(W)) u_addsub (
        .A   (A),
        .B   (B),
        .sub (use_sub),
        .sum (sum),
        .ovf (ovf_as)
    );

    // sign XOR overflow gives the true signed comparison even when A-B overflows.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (ALUctl)
            AND:      res_d = A & B;
            OR:       res_d = A | B;
            NOR:      res_d = ~(A | B);
            ADD: begin
                res_d = sum;
                ovf_d = ovf_as;
            end
            SUB: begin
                res_d = sum;
                ovf_d = ovf_as;
            end
            LESSTHAN: res_d = {{(W-1){1'b0}}, sum[W-1] ^ ovf_as};
            default: begin
                res_d = '0;
                ovf_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUout   <= '0;
            Overflow <= 1'b0;
            Zero     <= 1'b1;
        end else begin
            ALUout   <= res_d;
            Overflow <= ovf_d;
            Zero     <= (res_d == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops and compares.
// Directed corner vectors carry literal expectations; random traffic uses a signed-arithmetic model.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] MINS = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXS = {1'b0, {(W-1){1'b1}}};

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
        string        tag;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   ALUctl;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] ALUout;
    logic         Overflow;
    logic         Zero;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ALUctl   (ALUctl),
        .A        (A),
        .B        (B),
        .ALUout   (ALUout),
        .Overflow (Overflow),
        .Zero     (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: W+1-bit signed arithmetic; overflow when the true result leaves W-bit range.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input string tag);
        exp_t e;
        logic signed [W:0] sa, sb, wide;
        sa = $signed({a[W-1], a});
        sb = $signed({b[W-1], b});
        e.res = '0;
        e.ovf = 1'b0;
        e.tag = tag;
        case (op)
            AND: e.res = a & b;
            OR:  e.res = a | b;
            NOR: e.res = ~(a | b);
            ADD: begin
                wide  = sa + sb;
                e.res = wide[W-1:0];
                e.ovf = (wide[W] != wide[W-1]);
            end
            SUB: begin
                wide  = sa - sb;
                e.res = wide[W-1:0];
                e.ovf = (wide[W] != wide[W-1]);
            end
            LESSTHAN: e.res = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : '0;
            default: e.res = '0;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    function automatic exp_t reset_exp(input string tag);
        exp_t e;
        e.res  = '0;
        e.ovf  = 1'b0;
        e.zero = 1'b1;
        e.tag  = tag;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return MINS;
            1:       return MAXS;
            2:       return '1;
            3:       return '0;
            4:       return {{(W-1){1'b0}}, 1'b1};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic r, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        rst_n  = r;
        ALUctl = op;
        A      = a;
        B      = b;
        scb.push_back(e);
    endtask

    task automatic vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic o, input logic z, input string tag);
        exp_t e;
        e.res  = r;
        e.ovf  = o;
        e.zero = z;
        e.tag  = tag;
        drive(1'b1, op, a, b, e);
    endtask

    // Monitor: one result is due #1 after every rising edge that followed a push.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (scb.size() > 0) begin
            e = scb.pop_front();
            n_cmp++;
            if (ALUout !== e.res || Overflow !== e.ovf || Zero !== e.zero) begin
                n_bad++;
                $display("FAIL %s: got out=%h ovf=%b zero=%b, want out=%h ovf=%b zero=%b",
                         e.tag, ALUout, Overflow, Zero, e.res, e.ovf, e.zero);
            end
        end
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [3:0]   ops[6];
        logic [3:0]   undef_op;
        ops = '{AND, OR, ADD, SUB, LESSTHAN, NOR};
        undef_op = 4'b0011;
        rst_n  = 1'b0;
        ALUctl = ADD;
        A      = MAXS;
        B      = MAXS;

        drive(1'b0, ADD, MAXS, MAXS, reset_exp("reset0"));
        drive(1'b0, OR, '1, '1, reset_exp("reset1"));

        vec(SUB, MINS, 64'h1, MAXS, 1'b1, 1'b0, "sub_min_minus_1");
        vec(ADD, MAXS, 64'h1, MINS, 1'b1, 1'b0, "add_max_plus_1");
        vec(ADD, '1, 64'h1, '0, 1'b0, 1'b1, "add_wrap_zero");
        vec(LESSTHAN, MINS, 64'h1, 64'h1, 1'b0, 1'b0, "lt_min_vs_1");
        vec(LESSTHAN, 64'h1, '1, '0, 1'b0, 1'b1, "lt_1_vs_neg1");
        vec(LESSTHAN, MINS, MAXS, 64'h1, 1'b0, 1'b0, "lt_min_vs_max");
        vec(LESSTHAN, MAXS, MINS, '0, 1'b0, 1'b1, "lt_max_vs_min");
        vec(AND, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hF000F000F000F000, 1'b0, 1'b0, "and_pat");
        vec(OR,  64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hFFF0FFF0FFF0FFF0, 1'b0, 1'b0, "or_pat");
        vec(NOR, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'h000F000F000F000F, 1'b0, 1'b0, "nor_pat");
        vec(undef_op, '1, '1, '0, 1'b0, 1'b1, "undef_0011");
        vec(SUB, 64'h5, 64'h5, '0, 1'b0, 1'b1, "sub_equal_zero");
        vec(SUB, 64'h3, 64'h5, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, "sub_neg_result");

        // Hold check: inputs wiggle between edges, registered outputs must not follow.
        vec(ADD, 64'h10, 64'h20, 64'h30, 1'b0, 1'b0, "hold_edge");
        @(posedge clk);
        #2;
        ALUctl = NOR;
        A      = '0;
        B      = '0;
        #2;
        n_cmp++;
        if (ALUout !== 64'h30 || Overflow !== 1'b0 || Zero !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_midcycle: got out=%h ovf=%b zero=%b, want out=%h ovf=0 zero=0",
                     ALUout, Overflow, Zero, 64'h30);
        end

        // Reset in the middle of a SUB stream discards the op sampled at that edge.
        for (int i = 0; i < 4; i++) begin
            a = rand_operand();
            b = rand_operand();
            drive(1'b1, SUB, a, b, model(SUB, a, b, "sub_stream"));
        end
        drive(1'b0, SUB, MINS, 64'h1, reset_exp("midstream_reset"));
        drive(1'b1, SUB, MINS, 64'h1, model(SUB, MINS, 64'h1, "sub_after_reset"));
        drive(1'b1, SUB, 64'h9, 64'h4, model(SUB, 64'h9, 64'h4, "sub_after_reset2"));

        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 15);
            if (sel < 12) op = ops[sel % 6];
            else          op = 4'($urandom_range(0, 15));
            a = rand_operand();
            b = rand_operand();
            if ($urandom_range(0, 49) == 0)
                drive(1'b0, op, a, b, reset_exp("rand_reset"));
            else
                drive(1'b1, op, a, b, model(op, a, b, is_defined_op(op) ? "rand_op" : "rand_undef"));
        end

        @(posedge clk);
        #3;
        for (int i = 0; i < 5 && scb.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        if (scb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", scb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter W, default 64, giving the operand and result width in bits (W >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port ALUctl, input, 4 bits: operation select.
REQ-005 The block SHALL have port A, input, W bits: first operand, two's complement.
REQ-006 The block SHALL have port B, input, W bits: second operand, two's complement.
REQ-007 The block SHALL have port ALUout, output, W bits: registered result.
REQ-008 The block SHALL have port Overflow, output, 1 bit: registered signed-overflow flag.
REQ-009 The block SHALL have port Zero, output, 1 bit: registered flag, 1 when ALUout is all zeros.

Function
REQ-010 Opcodes SHALL be: AND 0000 = A&B; OR 0001 = A|B; ADD 0010 = A+B; SUB 0110 = A-B; LESSTHAN 0111 = signed A<B; NOR 1100 = ~(A|B).
REQ-011 ADD and SUB SHALL be computed modulo 2^W; SUB SHALL be A + ~B + 1 on a single W-bit adder.
REQ-012 Overflow SHALL be 1 for ADD when A and B have equal sign bits and the sum sign differs from them.
REQ-013 Overflow SHALL be 1 for SUB when A and B have different sign bits and the difference sign differs from A.
REQ-014 Overflow SHALL be 0 for AND, OR, NOR, LESSTHAN and undefined opcodes.
REQ-015 LESSTHAN SHALL output 1 in bit 0 (all other bits 0) when (sub sign XOR sub overflow) = 1, else all zeros; this is correct at all extremes, e.g. most-negative < 1.
REQ-016 Undefined opcodes SHALL produce ALUout = 0 and Overflow = 0.
REQ-017 Zero SHALL be 1 exactly when the registered ALUout value is all zeros, for every opcode.
REQ-018 Latency SHALL be one cycle: inputs sampled at rising edge N appear on ALUout/Overflow/Zero after edge N and hold until edge N+1.
REQ-019 The block SHALL accept a new operation every cycle with no handshake and no stall.
REQ-020 Outputs SHALL change only on rising clk edges; combinational input changes between edges SHALL NOT be visible at outputs.

Reset
REQ-021 When rst_n = 0 at a rising edge, ALUout SHALL become 0, Overflow 0 and Zero 1, regardless of ALUctl, A, B.
REQ-022 Reset asserted mid-stream SHALL discard the operation sampled at that edge; the first result after release is from the edge where rst_n = 1.
REQ-023 There SHALL be no asynchronous reset path.

Structure
REQ-024 Opcode constants (AND, OR, ADD, SUB, LESSTHAN, NOR) SHALL live in a shared package alu_pkg, used by the block and bench.
REQ-025 The adder/subtractor with overflow detection SHALL be a sub-module alu_addsub (parameter W; inputs A, B, sub; outputs sum, ovf), combinational.
REQ-026 alu SHALL contain the opcode decode, logic ops, result mux and output registers.

Verification
REQ-027 SUB, W=64, A=0x8000000000000000, B=0x1 -> next cycle ALUout=0x7FFFFFFFFFFFFFFF, Overflow=1, Zero=0.
REQ-028 ADD A=0x7FFFFFFFFFFFFFFF, B=0x1 -> ALUout=0x8000000000000000, Overflow=1; ADD A=0xFFFFFFFFFFFFFFFF, B=0x1 -> ALUout=0, Overflow=0, Zero=1.
REQ-029 LESSTHAN A=0x8000000000000000, B=0x1 -> ALUout=1; A=0x1, B=0xFFFFFFFFFFFFFFFF -> ALUout=0, Zero=1, Overflow=0.
REQ-030 AND/OR/NOR with A=0xF0F0F0F0F0F0F0F0, B=0xFF00FF00FF00FF00 -> 0xF000F000F000F000 / 0xFFF0FFF0FFF0FFF0 / 0x000F000F000F000F, Overflow=0.
REQ-031 Back-to-back ops each cycle -> each result appears exactly one cycle after its inputs; opcode 0011 -> ALUout=0, Zero=1.
REQ-032 rst_n=0 during active SUB stream -> after that edge ALUout=0, Overflow=0, Zero=1; operation resumes one cycle after rst_n=1.
